// File: rtl/not_db_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : not_db_pkg
//  Purpose  : Shared defaults and helpers for the inverting debouncer
//             (not_db) and its input synchronizer (not_db_sync).
//  Contents : DEF_SYNC_STAGES - default synchronizer depth
//             DEF_DB_CYCLES   - default debounce hold time in clocks
//             cnt_width()     - width of the debounce counter
//  Revision : 1.0  initial release
// ============================================================================
package not_db_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 4;

    // The counter must be able to hold 0..DB_CYCLES-1; sizing it for
    // DB_CYCLES keeps a width of at least one bit when DB_CYCLES is 1.
    function automatic int cnt_width(input int db_cycles);
        return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
    endfunction

endpackage : not_db_pkg
`default_nettype wire

// File: rtl/not_db_sync.sv
`default_nettype none
// ============================================================================
//  Module   : not_db_sync
//  Purpose  : STAGES-deep flop chain bringing an asynchronous level into
//             the clk domain. All stages clear to 0 on reset.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             d     - raw asynchronous input
//             q     - synchronized output (last stage)
//  Revision : 1.0  initial release
// ============================================================================
module not_db_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // sync_q[0] is the first (metastability-catching) stage.
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : not_db_sync
`default_nettype wire

// File: rtl/not_db.sv
`default_nettype none
// ============================================================================
//  Module   : not_db
//  Purpose  : Synchronize and debounce a raw level input, then present its
//             registered inverse together with one-cycle edge pulses.
//  Ports    : clk    - sole clock, rising edge
//             rst_n  - asynchronous active-low reset
//             x      - raw asynchronous level input
//             y      - registered inverse of the debounced level
//             y_rise - one-cycle pulse when y goes 0->1
//             y_fall - one-cycle pulse when y goes 1->0
//  Revision : 1.0  initial release
// ============================================================================
module not_db
    import not_db_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    output logic y,
    output logic y_rise,
    output logic y_fall
);

    localparam int               c_cnt_w    = cnt_width(DB_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic               w_x_sync;

    logic               s_q,      s_d;
    logic [c_cnt_w-1:0] c_q,      c_d;
    logic               y_q,      y_d;
    logic               y_rise_q, y_rise_d;
    logic               y_fall_q, y_fall_d;

    not_db_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (x),
        .q     (w_x_sync)
    );

    // Counter tracks how many consecutive clocks the synchronized input has
    // disagreed with the stable level. Any agreement restarts the count, so
    // only an uninterrupted run of DB_CYCLES disagreements is accepted. The
    // count stops at DB_CYCLES-1 because acceptance clears it.
    always_comb begin
        s_d = s_q;
        c_d = c_q;
        if (w_x_sync == s_q) begin
            c_d = '0;
        end else if (c_q == c_cnt_last) begin
            s_d = w_x_sync;
            c_d = '0;
        end else begin
            c_d = c_q + c_cnt_one;
        end
    end

    // y is registered from the next stable level so it moves on the same
    // edge as s; the pulses compare that next value with the current y.
    always_comb begin
        y_d      = ~s_d;
        y_rise_d =  y_d & ~y_q;
        y_fall_d = ~y_d &  y_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= 1'b0;
            c_q      <= '0;
            y_q      <= 1'b1;
            y_rise_q <= 1'b0;
            y_fall_q <= 1'b0;
        end else begin
            s_q      <= s_d;
            c_q      <= c_d;
            y_q      <= y_d;
            y_rise_q <= y_rise_d;
            y_fall_q <= y_fall_d;
        end
    end

    assign y      = y_q;
    assign y_rise = y_rise_q;
    assign y_fall = y_fall_q;

endmodule : not_db
`default_nettype wire

// File: tb/tb_not_db.sv
`default_nettype none
// ============================================================================
//  Module   : tb_not_db
//  Purpose  : Self-checking bench for not_db. Two instances share clk, rst_n
//             and x: one with default parameters, one with SYNC_STAGES=3 and
//             DB_CYCLES=1. A window-based reference model predicts y and the
//             edge pulses on every clock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_not_db;

    logic clk;
    logic rst_n;
    logic x;
    logic y0, y_rise0, y_fall0;
    logic y1, y_rise1, y_fall1;

    int checks = 0;
    int errors = 0;

    not_db dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (x),
        .y      (y0),
        .y_rise (y_rise0),
        .y_fall (y_fall0)
    );

    not_db #(
        .SYNC_STAGES (3),
        .DB_CYCLES   (1)
    ) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (x),
        .y      (y1),
        .y_rise (y_rise1),
        .y_fall (y_fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a pipe of SYNC_STAGES delays, then the debounced
    // level flips once the last DB_CYCLES synchronized samples all
    // disagree with it.
    // ------------------------------------------------------------------
    bit pipe [2][$];
    bit hist [2][$];
    bit ms   [2];
    bit ey   [2];
    bit er   [2];
    bit ef   [2];

    function automatic int stages_of(input int m);
        return (m == 0) ? 2 : 3;
    endfunction

    function automatic int db_of(input int m);
        return (m == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            pipe[m].delete();
            for (int k = 0; k < stages_of(m); k++) pipe[m].push_back(1'b0);
            hist[m].delete();
            ms[m] = 1'b0;
            ey[m] = 1'b1;
            er[m] = 1'b0;
            ef[m] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            bit xs;
            bit all_diff;
            bit prev_y;
            xs = pipe[m][0];
            void'(pipe[m].pop_front());
            pipe[m].push_back(x);
            hist[m].push_back(xs);
            while (hist[m].size() > db_of(m)) void'(hist[m].pop_front());
            all_diff = (hist[m].size() == db_of(m));
            foreach (hist[m][k]) if (hist[m][k] == ms[m]) all_diff = 1'b0;
            prev_y = ey[m];
            if (all_diff) ms[m] = ~ms[m];
            ey[m] = ~ms[m];
            er[m] = ey[m] & ~prev_y;
            ef[m] = ~ey[m] & prev_y;
        end
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("y0",      y0,      ey[0]);
        chk("y_rise0", y_rise0, er[0]);
        chk("y_fall0", y_fall0, ef[0]);
        chk("y1",      y1,      ey[1]);
        chk("y_rise1", y_rise1, er[1]);
        chk("y_fall1", y_fall1, ef[1]);
    endtask

    // One clock: update the model with the x present at the edge, then
    // compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Counts edges until each instance's y changes (bounded).
    task automatic measure(input int exp0, input int exp1);
        int   lat0;
        int   lat1;
        logic p0;
        logic p1;
        lat0 = 0;
        lat1 = 0;
        p0   = y0;
        p1   = y1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (lat0 == 0 && y0 !== p0) lat0 = i;
            if (lat1 == 0 && y1 !== p1) lat1 = i;
        end
        chk_int("latency0", lat0, exp0);
        chk_int("latency1", lat1, exp1);
    endtask

    // Asserts reset between edges and checks the immediate effect.
    task automatic async_reset(input int hold_edges);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_y0",      y0,      1'b1);
        chk("rst_y_fall0", y_fall0, 1'b0);
        chk("rst_y_rise0", y_rise0, 1'b0);
        chk("rst_y1",      y1,      1'b1);
        chk("rst_y_fall1", y_fall1, 1'b0);
        ticks(hold_edges);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed and random stimulus
    // ------------------------------------------------------------------
    initial begin
        logic saw_rise0;

        x     = 1'b0;
        rst_n = 1'b0;
        model_reset();

        // Reset state
        ticks(3);
        rst_n = 1'b1;

        // x low for 20 cycles: y stays 1, no pulses
        ticks(20);

        // 0->1 held: default instance after 6 edges, fast instance after 4
        x = 1'b1;
        measure(6, 4);

        // Short low pulse (3 cycles) is rejected by the default instance
        ticks(10);
        x = 1'b0;
        ticks(3);
        x = 1'b1;
        ticks(10);
        chk("glitch3_y0", y0, 1'b0);

        // 4-cycle low pulse is accepted: y0 rises for a while
        saw_rise0 = 1'b0;
        x = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (y_rise0 === 1'b1) saw_rise0 = 1'b1;
        end
        x = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (y_rise0 === 1'b1) saw_rise0 = 1'b1;
        end
        chk("pulse4_rise0", saw_rise0, 1'b1);

        // Toggle every 2 cycles for 40 cycles: default counter never hits 3
        for (int i = 0; i < 20; i++) begin
            x = ~x;
            tick();
            chk("cnt_below_3", logic'(dut0.c_q < 3), 1'b1);
            tick();
            chk("cnt_below_3", logic'(dut0.c_q < 3), 1'b1);
        end
        x = 1'b1;
        ticks(12);

        // Reset two cycles into a pending 0->1 change
        x = 1'b0;
        ticks(12);
        x = 1'b1;
        ticks(2);
        async_reset(2);
        measure(6, 4);

        // Random levels with random hold times and occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            x = 1'($urandom_range(0, 1));
            ticks(int'($urandom_range(1, 8)));
            if ($urandom_range(0, 14) == 0) async_reset(int'($urandom_range(1, 3)));
        end
        ticks(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_not_db
`default_nettype wire
